// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction loader ROM.
package imem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun
    } imem_state_e;

    localparam int unsigned WordWidth    = 32;
    localparam int unsigned DefaultDepth = 64;

endpackage

// File: rtl/imem_packer.sv
// Assembles accepted bytes little-endian into 32-bit words; flush emits a
// zero-padded partial word.
module imem_packer
    import imem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 accept_i,
    input  logic                 flush_i,
    input  logic [7:0]           byte_i,
    output logic                 word_we_o,
    output logic [WordWidth-1:0] word_o
);

    logic [1:0]           cnt_q;
    logic [WordWidth-1:0] data_q;

    // data_q is zeroed after every write, so unfilled upper bytes pad with zero.
    always_comb begin
        word_o = data_q;
        if (accept_i) begin
            word_o[{cnt_q, 3'b000} +: 8] = byte_i;
        end
        word_we_o = (accept_i && (cnt_q == 2'd3)) ||
                    (flush_i && (accept_i || (cnt_q != 2'd0)));
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q  <= 2'd0;
            data_q <= '0;
        end else if (word_we_o) begin
            cnt_q  <= 2'd0;
            data_q <= '0;
        end else if (accept_i) begin
            cnt_q  <= cnt_q + 2'd1;
            data_q <= word_o;
        end
    end

endmodule

// File: rtl/inst_loader_rom.sv
// Byte-stream program loader and CPU instruction ROM with IDLE/LOAD/RUN control.
// Optional IMEM_CHECKSUM_EN adds checksum_o, the XOR of bytes accepted this load.
module inst_loader_rom
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start_i,
    input  logic                 load_end_i,
    input  logic [7:0]           byte_i,
    input  logic                 byte_valid_i,
    output logic                 byte_ready_o,
    input  logic                 rom_ce_i,
    input  logic [31:0]          rom_addr_i,
    output logic [WordWidth-1:0] rom_data_o,
    output logic                 cpu_rst_o,
    output logic [8:0]           words_loaded_o
`ifdef IMEM_CHECKSUM_EN
    ,
    output logic [7:0]           checksum_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    imem_state_e          state_q;
    logic [AW-1:0]        ptr_q;
    logic [8:0]           words_q;
    logic                 cpu_rst_q;
    logic                 ready_q;

    logic                 accept;
    logic                 flush;
    logic                 clear;
    logic                 word_we;
    logic                 last_word;
    logic [WordWidth-1:0] word;

    logic [WordWidth-1:0] mem [DEPTH];

    assign accept    = byte_valid_i && ready_q;
    assign flush     = load_end_i && (state_q == StLoad);
    assign clear     = load_start_i && (state_q != StLoad);
    assign last_word = word_we && (ptr_q == AW'(DEPTH - 1));

    imem_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear),
        .accept_i  (accept),
        .flush_i   (flush),
        .byte_i    (byte_i),
        .word_we_o (word_we),
        .word_o    (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            words_q   <= 9'd0;
            cpu_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StRun: begin
                    if (load_start_i) begin
                        state_q   <= StLoad;
                        ptr_q     <= '0;
                        words_q   <= 9'd0;
                        cpu_rst_q <= 1'b1;
                        ready_q   <= 1'b1;
                    end
                end
                StLoad: begin
                    if (word_we) begin
                        ptr_q   <= ptr_q + AW'(1);
                        words_q <= words_q + 9'd1;
                    end
                    if (flush || last_word) begin
                        state_q   <= StRun;
                        cpu_rst_q <= 1'b0;
                        ready_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Memory is never reset; a reset cycle suppresses any pending write.
    always_ff @(posedge clk) begin
        if (word_we && !rst) begin
            mem[ptr_q] <= word;
        end
    end

    always_comb begin
        rom_data_o = '0;
        if ((state_q == StRun) && rom_ce_i && (rom_addr_i < 32'(4 * DEPTH))) begin
            rom_data_o = mem[rom_addr_i[AW+1:2]];
        end
    end

    assign byte_ready_o   = ready_q;
    assign cpu_rst_o      = cpu_rst_q;
    assign words_loaded_o = words_q;

`ifdef IMEM_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            csum_q <= 8'h00;
        end else if (accept) begin
            csum_q <= csum_q ^ byte_i;
        end
    end

    assign checksum_o = csum_q;
`endif

endmodule

// File: tb/tb_inst_loader_rom.sv
// Scoreboard bench for inst_loader_rom: stimulus queues expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_inst_loader_rom;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        load_end;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        cpu_rst;
    logic [8:0]  words_loaded;
`ifdef IMEM_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    inst_loader_rom #(
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load_start_i   (load_start),
        .load_end_i     (load_end),
        .byte_i         (byte_in),
        .byte_valid_i   (byte_valid),
        .byte_ready_o   (byte_ready),
        .rom_ce_i       (rom_ce),
        .rom_addr_i     (rom_addr),
        .rom_data_o     (rom_data),
        .cpu_rst_o      (cpu_rst),
        .words_loaded_o (words_loaded)
`ifdef IMEM_CHECKSUM_EN
        ,
        .checksum_o     (checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return rom_data;
            1:       return {31'b0, cpu_rst};
            2:       return {31'b0, byte_ready};
            3:       return {23'b0, words_loaded};
`ifdef IMEM_CHECKSUM_EN
            4:       return {24'b0, checksum};
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = observe(e.sel);
            checks++;
            if (act === e.val) begin
                passed++;
            end else begin
                $display("FAIL %s: got %08h expected %08h", e.name, act, e.val);
            end
        end
    end

    task automatic expect_val(input string n, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic read(input string n, input logic [31:0] a, input logic [31:0] e);
        rom_ce   = 1'b1;
        rom_addr = a;
        expect_val(n, 0, e);
        tick();
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulse_end();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    // Full-stream load uses byte n = n + 16.
    function automatic logic [31:0] word_of(input int j);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            w[8*k +: 8] = 8'(4 * j + k + 16);
        end
        return w;
    endfunction

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        load_end   = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        rom_ce     = 1'b0;
        rom_addr   = 32'h0;
        tick();
        tick();

        expect_val("rst_cpu_rst", 1, 32'd1);
        expect_val("rst_ready", 2, 32'd0);
        expect_val("rst_words", 3, 32'd0);
        read("rst_rom", 32'h0, 32'h0);
        rst = 1'b0;
        tick();

        // Two full words, then explicit end.
        pulse_start();
        expect_val("a_ready", 2, 32'd1);
        expect_val("a_cpu_rst_load", 1, 32'd1);
        for (int i = 1; i <= 8; i++) send(8'(i));
        pulse_end();
        expect_val("a_words", 3, 32'd2);
        expect_val("a_cpu_rst_run", 1, 32'd0);
        expect_val("a_ready_run", 2, 32'd0);
        read("a_mem0", 32'h0, 32'h04030201);
        read("a_mem1", 32'h4, 32'h08070605);
        read("a_mem1_unaligned", 32'h7, 32'h08070605);
        read("a_mem0_unaligned", 32'h3, 32'h04030201);
        read("a_out_of_range", 32'(4 * DEPTH), 32'h0);
        rom_ce   = 1'b0;
        rom_addr = 32'h4;
        expect_val("a_ce_low", 0, 32'h0);
        tick();

        // Partial word flushed with the last byte accepted alongside load_end.
        pulse_start();
        expect_val("b_words_cleared", 3, 32'd0);
        expect_val("b_cpu_rst", 1, 32'd1);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        send(8'hDD);
        byte_valid = 1'b1;
        byte_in    = 8'hEE;
        load_end   = 1'b1;
        tick();
        byte_valid = 1'b0;
        load_end   = 1'b0;
        expect_val("b_words", 3, 32'd2);
        expect_val("b_cpu_rst_run", 1, 32'd0);
`ifdef IMEM_CHECKSUM_EN
        expect_val("b_checksum", 4, 32'hEE);
`endif
        read("b_mem0", 32'h0, 32'hDDCCBBAA);
        read("b_mem1", 32'h4, 32'h000000EE);

        // Fill the whole memory without load_end.
        pulse_start();
        for (int n = 0; n < 4 * DEPTH; n++) send(8'(n + 16));
        byte_valid = 1'b1;
        byte_in    = 8'hFF;
        expect_val("c_ready_low", 2, 32'd0);
        expect_val("c_words_full", 3, 32'(DEPTH));
        expect_val("c_cpu_rst_run", 1, 32'd0);
        tick();
        tick();
        byte_valid = 1'b0;
        expect_val("c_words_after_extra", 3, 32'(DEPTH));
        read("c_mem_first", 32'h0, word_of(0));
        read("c_mem_last", 32'(4 * (DEPTH - 1)), word_of(DEPTH - 1));
        read("c_mem_last_top", 32'(4 * DEPTH - 1), word_of(DEPTH - 1));

        // Reset mid-load aborts without writing.
        pulse_start();
        send(8'h55);
        send(8'h66);
        send(8'h77);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_val("d_cpu_rst", 1, 32'd1);
        expect_val("d_words", 3, 32'd0);
        expect_val("d_ready", 2, 32'd0);
        read("d_rom_idle", 32'h0, 32'h0);
        pulse_start();
        pulse_end();
        expect_val("d_words_empty_load", 3, 32'd0);
        expect_val("d_cpu_rst_run", 1, 32'd0);
        read("d_mem0_kept", 32'h0, word_of(0));
        read("d_mem1_kept", 32'h4, word_of(1));

        // Single word; checksum clears on the next load start.
        pulse_start();
        send(8'h01);
        send(8'h02);
        send(8'h04);
        send(8'h08);
        expect_val("e_words", 3, 32'd1);
        expect_val("e_ready", 2, 32'd1);
`ifdef IMEM_CHECKSUM_EN
        expect_val("e_checksum", 4, 32'h0F);
`endif
        pulse_end();
        expect_val("e_cpu_rst_run", 1, 32'd0);
        read("e_mem0", 32'h0, 32'h08040201);
        pulse_start();
        expect_val("e_words_restart", 3, 32'd0);
`ifdef IMEM_CHECKSUM_EN
        expect_val("e_checksum_cleared", 4, 32'h00);
`endif
        tick();
        tick();

        if (sb.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
